// File: rtl/fifo_mmap_if.sv
`default_nettype none
// ============================================================================
//  fifo_mmap_if : CPU register bus plus TX/RX valid-ready streams of fifo_mmap
//  Revision     : 1.0
// ============================================================================
interface fifo_mmap_if #(
  parameter int DATA_W = 8
);
  logic [31:2]       addr;
  logic              re;
  logic [31:0]       rd;
  logic              we;
  logic [31:0]       wd;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              irq;

  modport master (
    output addr, re, we, wd, tx_ready, rx_valid, rx_data,
    input  rd, tx_valid, tx_data, rx_ready, irq
  );

  modport slave (
    input  addr, re, we, wd, tx_ready, rx_valid, rx_data,
    output rd, tx_valid, tx_data, rx_ready, irq
  );
endinterface
`default_nettype wire

// File: rtl/fifo_mmap.sv
`default_nettype none
// ============================================================================
//  fifo_mmap : memory-mapped TX/RX FIFO pair with sticky error flags and irq
//  Revision  : 1.0
// ============================================================================
module fifo_mmap #(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int RX_DROP  = 0
) (
  input  wire logic  clk,
  input  wire logic  reset,
  fifo_mmap_if.slave bus
);
  localparam int         TX_AW    = $clog2(TX_DEPTH);
  localparam int         RX_AW    = $clog2(RX_DEPTH);
  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;

  logic [DATA_W-1:0] r_tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] r_rx_mem [RX_DEPTH];
  logic [TX_AW:0]    r_tx_wptr, r_tx_rptr;
  logic [RX_AW:0]    r_rx_wptr, r_rx_rptr;
  logic              r_tx_ovf, r_rx_ovf, r_rx_udf;
  logic              r_irq_rx_en, r_irq_tx_en, r_irq;

  logic [1:0]  w_reg;
  logic        w_wr_data, w_wr_ctrl, w_rd_data;
  logic        w_tx_flush, w_rx_flush, w_clr;
  logic        w_tx_empty, w_tx_full, w_tx_pop, w_tx_push, w_tx_ovf_set;
  logic        w_rx_empty, w_rx_full, w_rx_pop, w_rx_push, w_rx_ovf_set, w_rx_udf_set;
  logic        w_rx_ready;
  logic [TX_AW:0] w_tx_count;
  logic [RX_AW:0] w_rx_count;
  logic [8:0]  w_tx_count9, w_rx_count9;
  logic [7:0]  w_tx_sat, w_rx_sat;
  logic [31:0] w_rd;
  logic        w_unused;

  assign w_reg      = bus.addr[3:2];
  assign w_wr_data  = bus.we && (w_reg == A_DATA);
  assign w_wr_ctrl  = bus.we && (w_reg == A_CTRL);
  assign w_rd_data  = bus.re && (w_reg == A_DATA);
  assign w_tx_flush = w_wr_ctrl && bus.wd[0];
  assign w_rx_flush = w_wr_ctrl && bus.wd[1];
  assign w_clr      = w_wr_ctrl && bus.wd[2];

  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[TX_AW] != r_tx_rptr[TX_AW]) &&
                      (r_tx_wptr[TX_AW-1:0] == r_tx_rptr[TX_AW-1:0]);
  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[RX_AW] != r_rx_rptr[RX_AW]) &&
                      (r_rx_wptr[RX_AW-1:0] == r_rx_rptr[RX_AW-1:0]);

  // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
  assign w_tx_pop     = !w_tx_empty && bus.tx_ready;
  assign w_tx_push    = w_wr_data && (!w_tx_full || w_tx_pop) && !w_tx_flush;
  assign w_tx_ovf_set = w_wr_data && w_tx_full && !w_tx_pop;

  assign w_rx_pop     = w_rd_data && !w_rx_empty;
  assign w_rx_udf_set = w_rd_data && w_rx_empty;
  assign w_rx_push    = bus.rx_valid && w_rx_ready && (!w_rx_full || w_rx_pop) && !w_rx_flush;

  generate
    if (RX_DROP != 0) begin : g_rx_drop
      assign w_rx_ready   = 1'b1;
      assign w_rx_ovf_set = bus.rx_valid && w_rx_full && !w_rx_pop && !w_rx_flush;
    end else begin : g_rx_backpressure
      assign w_rx_ready   = !w_rx_full;
      assign w_rx_ovf_set = 1'b0;
    end
  endgenerate

  assign w_tx_count  = r_tx_wptr - r_tx_rptr;
  assign w_rx_count  = r_rx_wptr - r_rx_rptr;
  assign w_tx_count9 = 9'(w_tx_count);
  assign w_rx_count9 = 9'(w_rx_count);
  assign w_tx_sat    = w_tx_count9[8] ? 8'hFF : w_tx_count9[7:0];
  assign w_rx_sat    = w_rx_count9[8] ? 8'hFF : w_rx_count9[7:0];

  always_comb begin
    w_rd = 32'd0;
    case (w_reg)
      A_DATA:   w_rd = w_rx_empty ? 32'd0 : 32'(r_rx_mem[r_rx_rptr[RX_AW-1:0]]);
      A_STATUS: w_rd = {8'd0, w_rx_sat, w_tx_sat, 1'b0, r_rx_udf, r_rx_ovf, r_tx_ovf,
                        w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
      A_CTRL:   w_rd = {26'd0, r_irq_tx_en, r_irq_rx_en, 4'd0};
      default:  w_rd = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_wptr   <= '0;
      r_tx_rptr   <= '0;
      r_rx_wptr   <= '0;
      r_rx_rptr   <= '0;
      r_tx_ovf    <= 1'b0;
      r_rx_ovf    <= 1'b0;
      r_rx_udf    <= 1'b0;
      r_irq_rx_en <= 1'b0;
      r_irq_tx_en <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_tx_flush) begin
        r_tx_wptr <= '0;
        r_tx_rptr <= '0;
      end else begin
        if (w_tx_push) r_tx_wptr <= r_tx_wptr + {{TX_AW{1'b0}}, 1'b1};
        if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + {{TX_AW{1'b0}}, 1'b1};
      end
      if (w_rx_flush) begin
        r_rx_wptr <= '0;
        r_rx_rptr <= '0;
      end else begin
        if (w_rx_push) r_rx_wptr <= r_rx_wptr + {{RX_AW{1'b0}}, 1'b1};
        if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + {{RX_AW{1'b0}}, 1'b1};
      end
      // A new event in the same cycle as a clear survives the clear.
      r_tx_ovf <= (r_tx_ovf && !w_clr) || w_tx_ovf_set;
      r_rx_ovf <= (r_rx_ovf && !w_clr) || w_rx_ovf_set;
      r_rx_udf <= (r_rx_udf && !w_clr) || w_rx_udf_set;
      if (w_wr_ctrl) begin
        r_irq_rx_en <= bus.wd[4];
        r_irq_tx_en <= bus.wd[5];
      end
      r_irq <= (r_irq_rx_en && !w_rx_empty) || (r_irq_tx_en && w_tx_empty);
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[TX_AW-1:0]] <= bus.wd[DATA_W-1:0];
    if (w_rx_push) r_rx_mem[r_rx_wptr[RX_AW-1:0]] <= bus.rx_data;
  end

  assign bus.rd       = w_rd;
  assign bus.tx_valid = !w_tx_empty;
  assign bus.tx_data  = r_tx_mem[r_tx_rptr[TX_AW-1:0]];
  assign bus.rx_ready = w_rx_ready;
  assign bus.irq      = r_irq;

  assign w_unused = &{1'b0, bus.addr[31:4], bus.wd};
endmodule
`default_nettype wire

// File: tb/tb_fifo_mmap.sv
`default_nettype none
// ============================================================================
//  tb_fifo_mmap : scoreboard bench; dut0 uses RX backpressure, dut1 RX drop
//  Revision     : 1.0
// ============================================================================
module tb_fifo_mmap;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:2] s_addr     = '0;
  logic        s_re       = 1'b0;
  logic        s_we       = 1'b0;
  logic [31:0] s_wd       = '0;
  logic        s_tx_ready = 1'b0;
  logic        s_rx_valid = 1'b0;
  logic [7:0]  s_rx_data  = '0;

  fifo_mmap_if #(.DATA_W(8)) bus0 ();
  fifo_mmap_if #(.DATA_W(8)) bus1 ();

  assign bus0.addr = s_addr;      assign bus1.addr = s_addr;
  assign bus0.re = s_re;          assign bus1.re = s_re;
  assign bus0.we = s_we;          assign bus1.we = s_we;
  assign bus0.wd = s_wd;          assign bus1.wd = s_wd;
  assign bus0.tx_ready = s_tx_ready; assign bus1.tx_ready = s_tx_ready;
  assign bus0.rx_valid = s_rx_valid; assign bus1.rx_valid = s_rx_valid;
  assign bus0.rx_data = s_rx_data;   assign bus1.rx_data = s_rx_data;

  fifo_mmap #(.DATA_W(8), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .RX_DROP(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  fifo_mmap #(.DATA_W(8), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .RX_DROP(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  logic [1:0]       o_txv, o_rxr, o_irq;
  logic [1:0][7:0]  o_txd;
  logic [1:0][31:0] o_rd;
  assign o_txv = {bus1.tx_valid, bus0.tx_valid};
  assign o_rxr = {bus1.rx_ready, bus0.rx_ready};
  assign o_irq = {bus1.irq, bus0.irq};
  assign o_txd = {bus1.tx_data, bus0.tx_data};
  assign o_rd  = {bus1.rd, bus0.rd};

  typedef struct packed {
    logic        re;
    logic        txv;
    logic [7:0]  txd;
    logic [1:0]  rxr;
    logic [1:0]  irq;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Reference model: plain queues and flags, updated once per clock.
  logic [7:0] m_tx[$];
  logic [7:0] m_rx0[$];
  logic [7:0] m_rx1[$];
  bit         m_tx_ovf;
  bit [1:0]   m_rx_ovf, m_rx_udf, m_irq;
  bit         m_en_rx, m_en_tx;

  task automatic model_reset();
    m_tx.delete(); m_rx0.delete(); m_rx1.delete();
    m_tx_ovf = 0; m_rx_ovf = 0; m_rx_udf = 0; m_irq = 0;
    m_en_rx = 0; m_en_tx = 0;
  endtask

  function automatic logic [31:0] status_word(input int txn, input int rxn,
                                              input bit txo, input bit rxo, input bit udf);
    logic [31:0] s;
    s = '0;
    s[0] = (txn == 0);
    s[1] = (txn == DEPTH);
    s[2] = (rxn == 0);
    s[3] = (rxn == DEPTH);
    s[4] = txo;
    s[5] = rxo;
    s[6] = udf;
    s[15:8]  = (txn > 255) ? 8'hFF : 8'(txn);
    s[23:16] = (rxn > 255) ? 8'hFF : 8'(rxn);
    return s;
  endfunction

  task automatic cycle(input logic [1:0] a, input logic r, input logic w, input logic [31:0] d,
                       input logic tr, input logic rv, input logic [7:0] rdat);
    exp_t        e;
    logic [7:0]  q[$];
    logic [31:0] rdv;
    bit ctrl_wr, tx_flush, rx_flush, clr, data_rd, tx_push_req, tx_full, tx_pop;
    bit rx_full, rx_pop, hs, ovf_set, udf_set, tx_ovf_set;
    bit [1:0] nxt_irq;
    s_addr = {28'($urandom), a};
    s_re = r; s_we = w; s_wd = d;
    s_tx_ready = tr; s_rx_valid = rv; s_rx_data = rdat;

    ctrl_wr     = w && (a == 2'd2);
    tx_flush    = ctrl_wr && d[0];
    rx_flush    = ctrl_wr && d[1];
    clr         = ctrl_wr && d[2];
    data_rd     = r && (a == 2'd0);
    tx_push_req = w && (a == 2'd0);

    e     = '0;
    e.re  = r;
    e.txv = (m_tx.size() != 0);
    e.txd = e.txv ? m_tx[0] : 8'h00;

    for (int k = 0; k < 2; k++) begin
      if (k == 0) q = m_rx0; else q = m_rx1;
      rx_full    = (q.size() == DEPTH);
      e.rxr[k]   = (k == 1) ? 1'b1 : !rx_full;
      e.irq[k]   = m_irq[k];
      case (a)
        2'd0:    rdv = (q.size() == 0) ? 32'd0 : {24'd0, q[0]};
        2'd1:    rdv = status_word(m_tx.size(), q.size(), m_tx_ovf, m_rx_ovf[k], m_rx_udf[k]);
        2'd2:    rdv = {26'd0, m_en_tx, m_en_rx, 4'd0};
        default: rdv = 32'd0;
      endcase
      if (k == 0) e.rd0 = rdv; else e.rd1 = rdv;
      nxt_irq[k] = (m_en_rx && q.size() != 0) || (m_en_tx && m_tx.size() == 0);

      rx_pop  = data_rd && (q.size() != 0);
      udf_set = data_rd && (q.size() == 0);
      hs      = rv && e.rxr[k];
      ovf_set = !rx_flush && hs && rx_full && !rx_pop;
      if (rx_flush) q.delete();
      else begin
        if (rx_pop) void'(q.pop_front());
        if (hs && (!rx_full || rx_pop)) q.push_back(rdat);
      end
      m_rx_ovf[k] = (m_rx_ovf[k] && !clr) || ovf_set;
      m_rx_udf[k] = (m_rx_udf[k] && !clr) || udf_set;
      if (k == 0) m_rx0 = q; else m_rx1 = q;
    end

    tx_full    = (m_tx.size() == DEPTH);
    tx_pop     = e.txv && tr;
    tx_ovf_set = tx_push_req && tx_full && !tx_pop;
    if (tx_flush) m_tx.delete();
    else begin
      if (tx_pop) void'(m_tx.pop_front());
      if (tx_push_req && (!tx_full || tx_pop)) m_tx.push_back(d[7:0]);
    end
    m_tx_ovf = (m_tx_ovf && !clr) || tx_ovf_set;
    if (ctrl_wr) begin
      m_en_rx = d[4];
      m_en_tx = d[5];
    end
    m_irq = nxt_irq;

    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  exp_t mrec;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mrec = exp_q.pop_front();
      for (int k = 0; k < 2; k++) begin
        check("tx_valid", k, 32'(o_txv[k]), 32'(mrec.txv));
        if (mrec.txv) check("tx_data", k, 32'(o_txd[k]), 32'(mrec.txd));
        check("rx_ready", k, 32'(o_rxr[k]), 32'(mrec.rxr[k]));
        check("irq", k, 32'(o_irq[k]), 32'(mrec.irq[k]));
        if (mrec.re) check("rd", k, o_rd[k], (k == 0) ? mrec.rd0 : mrec.rd1);
      end
    end
  end

  task automatic random_phase(input int n, input int p_tr, input int p_rv, input int p_rd, input int p_wr);
    logic [1:0]  a;
    logic [31:0] d;
    int          x;
    for (int i = 0; i < n; i++) begin
      x = $urandom_range(0, 9);
      a = (x < 5) ? 2'd0 : (x < 8) ? 2'd1 : (x == 8) ? 2'd2 : 2'd3;
      d = $urandom;
      if (a == 2'd2) begin
        if ($urandom_range(0, 15) != 0) d[1:0] = 2'b00;
        if ($urandom_range(0, 7) != 0)  d[2]   = 1'b0;
      end
      cycle(a, $urandom_range(0, 99) < p_rd, $urandom_range(0, 99) < p_wr, d,
            $urandom_range(0, 99) < p_tr, $urandom_range(0, 99) < p_rv, 8'($urandom));
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset tx_valid", k, 32'(o_txv[k]), 32'd0);
      check("reset rx_ready", k, 32'(o_rxr[k]), 32'd1);
      check("reset irq", k, 32'(o_irq[k]), 32'd0);
    end
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    cycle(2'd1, 1, 0, 32'd0, 0, 0, 8'd0);
    cycle(2'd0, 0, 1, 32'h11, 1, 0, 8'd0);
    cycle(2'd0, 0, 1, 32'h22, 1, 0, 8'd0);
    cycle(2'd0, 0, 1, 32'h33, 1, 0, 8'd0);
    repeat (3) cycle(2'd1, 1, 0, 32'd0, 1, 0, 8'd0);

    // TX overflow: 17 writes with the sink stalled, then drain
    for (int i = 0; i < 17; i++) cycle(2'd0, 0, 1, 32'h40 + i, 0, 0, 8'd0);
    cycle(2'd1, 1, 0, 32'd0, 0, 0, 8'd0);
    for (int i = 0; i < 18; i++) cycle(2'd1, 1, 0, 32'd0, 1, 0, 8'd0);

    // RX fill beyond depth: backpressure on dut0, drops on dut1
    for (int i = 0; i < 20; i++) cycle(2'd1, 1, 0, 32'd0, 0, 1, 8'h80 + 8'(i));
    cycle(2'd0, 1, 0, 32'd0, 0, 0, 8'd0);
    cycle(2'd1, 1, 0, 32'd0, 0, 0, 8'd0);
    cycle(2'd2, 0, 1, 32'h4, 0, 0, 8'd0);
    cycle(2'd1, 1, 0, 32'd0, 0, 0, 8'd0);
    for (int i = 0; i < 17; i++) cycle(2'd0, 1, 0, 32'd0, 0, 0, 8'd0);
    cycle(2'd1, 1, 0, 32'd0, 0, 0, 8'd0);

    // RX interrupt: enable, push one word, pop it
    cycle(2'd2, 1, 1, 32'h17, 0, 0, 8'd0);
    cycle(2'd0, 1, 0, 32'd0, 0, 0, 8'd0);
    cycle(2'd1, 1, 0, 32'd0, 0, 1, 8'h5A);
    repeat (2) cycle(2'd1, 1, 0, 32'd0, 0, 0, 8'd0);
    cycle(2'd0, 1, 0, 32'd0, 0, 0, 8'd0);
    repeat (2) cycle(2'd2, 1, 0, 32'd0, 0, 0, 8'd0);
    cycle(2'd2, 0, 1, 32'h20, 0, 0, 8'd0);
    repeat (2) cycle(2'd3, 1, 1, 32'hFFFF_FFFF, 0, 0, 8'd0);

    for (int ph = 0; ph < 6; ph++) begin
      if (ph % 2 == 0) random_phase(500, 20, 80, 10, 60);
      else             random_phase(500, 90, 20, 70, 10);
    end

    // Asynchronous reset with five words held in TX
    cycle(2'd2, 0, 1, 32'h3, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) cycle(2'd0, 0, 1, 32'hA0 + i, 0, 0, 8'd0);
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("async reset tx_valid", k, 32'(o_txv[k]), 32'd0);
      check("async reset rx_ready", k, 32'(o_rxr[k]), 32'd1);
      check("async reset irq", k, 32'(o_irq[k]), 32'd0);
    end
    model_reset();
    s_tx_ready = 1'b1; s_rx_valid = 1'b1; s_we = 1'b1; s_addr = '0;
    repeat (2) @(posedge clk);
    s_tx_ready = 1'b0; s_rx_valid = 1'b0; s_we = 1'b0;
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    cycle(2'd1, 1, 0, 32'd0, 0, 0, 8'd0);
    cycle(2'd0, 1, 0, 32'd0, 1, 0, 8'd0);

    @(negedge clk);
    #1;
    check("scoreboard drained", 0, 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
